// File: rtl/pixel_window_gen.sv
// Streaming 3x3 RGB window generator with two line buffers, raster-order input, 1-clk window latency.
// Optional `FRAME_DONE_EN adds frame_done (last-window pulse) and sof_err (sticky early-sof flag).
module pixel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 24
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
`ifdef FRAME_DONE_EN
  output logic               frame_done,
  output logic               sof_err,
`endif
  output logic               busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t             state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;

  logic [PIX_W-1:0]   lb_a [IMG_W];
  logic [PIX_W-1:0]   lb_b [IMG_W];

  // Index 1 holds column c-2, index 0 holds column c-1, relative to the pixel being accepted.
  logic [PIX_W-1:0]   sr_top [2];
  logic [PIX_W-1:0]   sr_mid [2];
  logic [PIX_W-1:0]   sr_bot [2];

  logic               accept;
  logic               last_pix;
  logic               emit;
  logic [CW-1:0]      acc_col;
  logic [RW-1:0]      acc_row;
  logic [PIX_W-1:0]   rd_a;
  logic [PIX_W-1:0]   rd_b;
  logic [9*PIX_W-1:0] window;

  // An in_sof pixel is always position (0,0), regardless of where the counters stood.
  always_comb begin
    accept   = in_valid && (in_sof || (state != IDLE));
    acc_col  = in_sof ? '0 : col;
    acc_row  = in_sof ? '0 : row;
    rd_a     = lb_a[acc_col];
    rd_b     = lb_b[acc_col];
    last_pix = accept && !in_sof && (col == COL_LAST) && (row == ROW_LAST);
    emit     = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
    window   = {sr_top[1], sr_top[0], rd_b,
                sr_mid[1], sr_mid[0], rd_a,
                sr_bot[1], sr_bot[0], in_pixel};
  end

  always_ff @(posedge clk) begin
    if (n_rst && accept) begin
      lb_b[acc_col] <= rd_a;
      lb_a[acc_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sr_top[i] <= '0;
        sr_mid[i] <= '0;
        sr_bot[i] <= '0;
      end
`ifdef FRAME_DONE_EN
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
`endif
    end else begin
      win_valid <= emit;
      if (emit) win_data <= window;
`ifdef FRAME_DONE_EN
      frame_done <= last_pix;
      if (in_valid && in_sof && (state != IDLE)) sof_err <= 1'b1;
`endif
      if (accept) begin
        sr_top[1] <= sr_top[0];
        sr_mid[1] <= sr_mid[0];
        sr_bot[1] <= sr_bot[0];
        sr_top[0] <= rd_b;
        sr_mid[0] <= rd_a;
        sr_bot[0] <= in_pixel;
        busy      <= !last_pix;
        if (in_sof) begin
          col   <= CW'(1);
          row   <= '0;
          state <= FILL;
        end else if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row   <= '0;
            state <= IDLE;
          end else begin
            row <= row + 1'b1;
            if (row == RW'(1)) state <= STREAM;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_gen.sv
// Scoreboard bench for pixel_window_gen: a whole-frame image model predicts every window.
// Works with or without `FRAME_DONE_EN defined.
module tb_pixel_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
  logic          win_valid;
  logic [215:0]  win_data;
  logic          busy;
`ifdef FRAME_DONE_EN
  logic          frame_done;
  logic          sof_err;
`endif

  pixel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .win_valid (win_valid),
    .win_data  (win_data),
`ifdef FRAME_DONE_EN
    .frame_done(frame_done),
    .sof_err   (sof_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  cyc;
    logic [215:0] data;
    bit           last;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int win_seen = 0;
  int fd_seen = 0;

  // Reference model: the current frame as a plain 2D image plus a raster position.
  bit            m_in_frame = 0;
  int            m_r = 0;
  int            m_c = 0;
  bit            m_sof_err = 0;
  int            m_frames = 0;
  logic [PW-1:0] m_img [H][W];

  task automatic model_accept(input bit v, input bit sof, input logic [PW-1:0] pix);
    exp_t e;
    if (!(v && (sof || m_in_frame))) return;
    if (sof) begin
      if (m_in_frame) m_sof_err = 1;
      m_in_frame = 1;
      m_r = 0;
      m_c = 0;
    end
    m_img[m_r][m_c] = pix;
    if (m_r >= 2 && m_c >= 2) begin
      e.cyc  = cyc + 1;
      e.data = '0;
      for (int k = 0; k < 9; k++)
        e.data[(8-k)*PW +: PW] = m_img[m_r-2+k/3][m_c-2+k%3];
      e.last = (m_r == H-1) && (m_c == W-1);
      sb.push_back(e);
    end
    if (m_r == H-1 && m_c == W-1) begin
      m_in_frame = 0;
      m_r = 0;
      m_c = 0;
      m_frames++;
    end else if (m_c == W-1) begin
      m_c = 0;
      m_r++;
    end else begin
      m_c++;
    end
  endtask

  task automatic check_output(input string name, input logic [215:0] actual, input logic [215:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; drives one cycle of input and returns at the next negedge.
  task automatic apply_stimulus(input bit v, input bit sof, input logic [PW-1:0] pix);
    in_valid = v;
    in_sof   = sof;
    in_pixel = pix;
    model_accept(v, sof, pix);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [PW-1:0] pix);
    n_rst    = 1'b0;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = pix;
    m_in_frame = 0;
    m_r = 0;
    m_c = 0;
    m_sof_err = 0;
    @(negedge clk);
    n_rst    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input logic [7:0] tag,
                            input bit with_sof, input bit gappy, input bit rnd);
    for (int i = first; i <= last; i++) begin
      int r = i / W;
      int c = i % W;
      logic [PW-1:0] p;
      if (gappy) repeat ($urandom_range(0, 2)) apply_stimulus(0, 0, 24'($urandom));
      p = rnd ? 24'($urandom) : {tag, 8'(r), 8'(c)};
      apply_stimulus(1, with_sof && (i == first), p);
    end
  endtask

  task automatic expect_windows(input string name, input int base, input int n);
    repeat (2) apply_stimulus(0, 0, '0);
    check_output(name, 216'(win_seen - base), 216'(n));
  endtask

  exp_t mon_e;
  bit   mon_exp;

  always @(negedge clk) begin
    mon_exp = 0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e   = sb.pop_front();
      mon_exp = 1;
    end
    if (win_valid === 1'b1) win_seen++;
    if (mon_exp) begin
      vectors++;
      if (win_valid !== 1'b1 || win_data !== mon_e.data) begin
        miscompares++;
        $display("[TB] FAIL window @%0d: got valid=%0b data=%h expected valid=1 data=%h",
                 cyc, win_valid, win_data, mon_e.data);
      end
    end else if (win_valid !== 1'b0 && n_rst === 1'b1 && cyc > 2) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_window @%0d: got win_valid=%b expected 0", cyc, win_valid);
    end
`ifdef FRAME_DONE_EN
    if (frame_done === 1'b1) fd_seen++;
    if (frame_done !== 1'b0 || (mon_exp && mon_e.last)) begin
      vectors++;
      if (frame_done !== (mon_exp && mon_e.last)) begin
        miscompares++;
        $display("[TB] FAIL frame_done @%0d: got %b expected %b", cyc, frame_done, mon_exp && mon_e.last);
      end
    end
`endif
  end

  int base;

  initial begin
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    @(negedge clk);
    @(negedge clk);
    check_output("reset_win_valid", 216'(win_valid), 216'(0));
    check_output("reset_win_data", win_data, '0);
    check_output("reset_busy", 216'(busy), 216'(0));
`ifdef FRAME_DONE_EN
    check_output("reset_frame_done", 216'(frame_done), 216'(0));
    check_output("reset_sof_err", 216'(sof_err), 216'(0));
`endif
    n_rst = 1'b1;

    base = win_seen;
    send_range(0, 15, 8'h00, 1, 0, 0);
    expect_windows("basic_count", base, 4);
    check_output("basic_busy_after", 216'(busy), 216'(0));

    base = win_seen;
    send_range(0, 15, 8'h00, 1, 1, 0);
    expect_windows("gappy_count", base, 4);

    base = win_seen;
    send_range(0, 9, 8'h11, 0, 0, 0);
    check_output("drop_busy", 216'(busy), 216'(0));
    expect_windows("drop_count", base, 0);
    base = win_seen;
    send_range(0, 15, 8'h22, 1, 0, 0);
    expect_windows("after_drop_count", base, 4);
`ifdef FRAME_DONE_EN
    check_output("sof_err_clean", 216'(sof_err), 216'(m_sof_err));
`endif

    base = win_seen;
    send_range(0, 8, 8'h33, 1, 0, 0);
    check_output("partial_busy", 216'(busy), 216'(1));
    send_range(0, 15, 8'h44, 1, 0, 0);
    expect_windows("sof_mid_count", base, 4);
`ifdef FRAME_DONE_EN
    check_output("sof_err_set", 216'(sof_err), 216'(m_sof_err));
`endif

    base = win_seen;
    repeat (3) send_range(0, 15, 8'h00, 1, 1, 1);
    expect_windows("random_count", base, 12);

    base = win_seen;
    send_range(0, 12, 8'h55, 1, 0, 0);
    apply_reset({8'h55, 8'd3, 8'd1});
    check_output("midreset_win_valid", 216'(win_valid), 216'(0));
    check_output("midreset_win_data", win_data, '0);
    check_output("midreset_busy", 216'(busy), 216'(0));
`ifdef FRAME_DONE_EN
    check_output("midreset_sof_err", 216'(sof_err), 216'(0));
`endif
    send_range(13, 15, 8'h55, 0, 0, 0);
    expect_windows("midreset_count", base, 2);
    check_output("midreset_busy_after", 216'(busy), 216'(0));

    base = win_seen;
    send_range(0, 15, 8'h66, 1, 1, 0);
    expect_windows("final_count", base, 4);
`ifdef FRAME_DONE_EN
    check_output("frame_done_total", 216'(fd_seen), 216'(m_frames));
`endif
    check_output("scoreboard_empty", 216'(sb.size()), 216'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
